// File: rtl/sync_cntr_n.sv
// Parametrised synchronous modulo counter with load, up/down, wrap/saturate ends,
// combinational terminal count for cascading, and registered wrap/overflow status.
module sync_cntr_n #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             cnt_en,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   // Top of range; for MODULUS = 2^WIDTH this is all ones, so +1 is never needed at the end.
   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

   logic [WIDTH-1:0] count_d, count_q;
   logic             wrap_d, wrap_q;
   logic             ovf_d, ovf_q;
   logic             at_top_s, at_bot_s, term_s;
   logic [WIDTH-1:0] load_clamped_s;

   // End-of-range detection and terminal event for the current direction
   always_comb begin
      at_top_s = (count_q == MAX_C);
      at_bot_s = (count_q == ZERO_C);
      if (cnt_en && !clr && !load) begin
         term_s = up_dn ? at_top_s : at_bot_s;
      end else begin
         term_s = 1'b0;
      end
   end

   // Clamp the parallel-load value into the legal count range
   always_comb begin
      if (load_val > MAX_C) begin
         load_clamped_s = MAX_C;
      end else begin
         load_clamped_s = load_val;
      end
   end

   // Next count: clr > load > count > hold
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = ZERO_C;
      end else if (load) begin
         count_d = load_clamped_s;
      end else if (cnt_en) begin
         if (up_dn) begin
            if (at_top_s) begin
               count_d = sat ? MAX_C : ZERO_C;
            end else begin
               count_d = count_q + ONE_C;
            end
         end else begin
            if (at_bot_s) begin
               count_d = sat ? ZERO_C : MAX_C;
            end else begin
               count_d = count_q - ONE_C;
            end
         end
      end else begin
         count_d = count_q;
      end
   end

   // Status next-state: wrap pulse and sticky overflow where setting beats clearing
   always_comb begin
      wrap_d = term_s & ~sat;
      if (term_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= ZERO_C;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign ovf   = ovf_q;
   assign tc    = term_s;

endmodule

// File: tb/tb_sync_cntr_n.sv
// Directed bench for sync_cntr_n: reset/count sequence, table of single-edge vectors,
// and a two-stage decade cascade counting to 100.
module tb_sync_cntr_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr, cnt_en, up_dn, sat, load, clr_ovf;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc, wrap, ovf;

   logic       casc_en;
   logic [3:0] c0_count, c1_count;
   logic       c0_tc, c0_wrap, c0_ovf, c1_tc, c1_wrap, c1_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_cntr_n #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .clr(clr), .cnt_en(cnt_en), .up_dn(up_dn),
      .sat(sat), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count), .tc(tc), .wrap(wrap), .ovf(ovf)
   );

   sync_cntr_n #(.WIDTH(4), .MODULUS(10)) c0 (
      .clk(clk), .reset(reset), .clr(1'b0), .cnt_en(casc_en), .up_dn(1'b1),
      .sat(1'b0), .load(1'b0), .load_val(4'd0), .clr_ovf(1'b0),
      .count(c0_count), .tc(c0_tc), .wrap(c0_wrap), .ovf(c0_ovf)
   );

   sync_cntr_n #(.WIDTH(4), .MODULUS(10)) c1 (
      .clk(clk), .reset(reset), .clr(1'b0), .cnt_en(c0_tc), .up_dn(1'b1),
      .sat(1'b0), .load(1'b0), .load_val(4'd0), .clr_ovf(1'b0),
      .count(c1_count), .tc(c1_tc), .wrap(c1_wrap), .ovf(c1_ovf)
   );

   typedef struct {
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic       en;
      logic       up;
      logic       sat;
      logic       covf;
      logic       tc;
      logic [3:0] cnt;
      logic       wrap;
      logic       ovf;
   } vec_t;

   vec_t vecs[25];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      // fields: clr load lv en up sat covf | tc_before | count wrap ovf after edge
      vecs[0]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
      vecs[20] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1};
      vecs[21] = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1};
      vecs[22] = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1};
      vecs[23] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      vecs[24] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

      reset = 1'b0; clr = 1'b0; cnt_en = 1'b0; up_dn = 1'b1; sat = 1'b0;
      load = 1'b0; clr_ovf = 1'b0; load_val = 4'd0; casc_en = 1'b0;
      #3;
      chk("reset_count", int'(count), 0);
      chk("reset_wrap", int'(wrap), 0);
      chk("reset_ovf", int'(ovf), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1; cnt_en = 1'b1; up_dn = 1'b1; sat = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         chk("pre_count", int'(count), i);
      end

      // asynchronous reset mid-count at 6
      reset = 1'b0;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_wrap", int'(wrap), 0);
      chk("async_rst_ovf", int'(ovf), 0);
      @(posedge clk); #1;
      chk("rst_hold_count", int'(count), 0);
      reset = 1'b1;

      // count 1..9,0 with up wrap
      for (int i = 1; i <= 10; i++) begin
         #1;
         chk("up_tc", int'(tc), (i == 10) ? 1 : 0);
         @(posedge clk); #1;
         chk("up_count", int'(count), i % 10);
         chk("up_wrap", int'(wrap), (i == 10) ? 1 : 0);
         chk("up_ovf", int'(ovf), (i == 10) ? 1 : 0);
      end
      @(posedge clk); #1;
      chk("post_wrap_count", int'(count), 1);
      chk("post_wrap_wrap", int'(wrap), 0);
      chk("post_wrap_ovf", int'(ovf), 1);

      foreach (vecs[k]) begin
         clr = vecs[k].clr; load = vecs[k].load; load_val = vecs[k].lv;
         cnt_en = vecs[k].en; up_dn = vecs[k].up; sat = vecs[k].sat;
         clr_ovf = vecs[k].covf;
         #1;
         chk($sformatf("vec%0d_tc", k), int'(tc), int'(vecs[k].tc));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_count", k), int'(count), int'(vecs[k].cnt));
         chk($sformatf("vec%0d_wrap", k), int'(wrap), int'(vecs[k].wrap));
         chk($sformatf("vec%0d_ovf", k), int'(ovf), int'(vecs[k].ovf));
      end
      clr = 1'b0; load = 1'b0; cnt_en = 1'b0; clr_ovf = 1'b0;

      // two-stage decade cascade, 100 edges back to 00
      chk("casc_start_lo", int'(c0_count), 0);
      chk("casc_start_hi", int'(c1_count), 0);
      casc_en = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         chk("casc_lo", int'(c0_count), i % 10);
         chk("casc_hi", int'(c1_count), (i / 10) % 10);
         chk("casc_hi_wrap", int'(c1_wrap), (i == 100) ? 1 : 0);
         chk("casc_hi_ovf", int'(c1_ovf), (i == 100) ? 1 : 0);
      end
      casc_en = 1'b0;
      @(posedge clk); #1;
      chk("casc_hold_lo", int'(c0_count), 0);
      chk("casc_hold_hi", int'(c1_count), 0);
      chk("casc_wrap_end", int'(c1_wrap), 0);
      chk("casc_ovf_sticky", int'(c1_ovf), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
